// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  // Bus level seen in an acknowledge slot.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK,
    WAIT_STOP
  } slave_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and derives edge / START / STOP strobes.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_dly_q, sda_dly_q;
  logic                   scl_s;

  // Synchronizer chains plus one delay flop each; idle bus level is 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
      sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s       = scl_sync_q[SYNC_STAGES-1];
  assign sda_o       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o  = scl_s & ~scl_dly_q;
  assign scl_fall_o  = ~scl_s & scl_dly_q;
  // SDA only moves while SCL is high for START/STOP.
  assign start_det_o = scl_s & ~sda_o & sda_dly_q;
  assign stop_det_o  = scl_s & sda_o & ~sda_dly_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, byte receive and byte transmit.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] OWN_ADDR    = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2c_scl,
  inout  wire                   i2c_sda,
  input  logic                  rx_ack_en,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_req,
  output logic                  busy
);

  slave_state_t          state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0] shreg_q, shreg_d, sh_in;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rw_q, rw_d;
  logic                  done_q, done_d;     // 8th rise of the current byte seen
  logic                  acked_q, acked_d;   // we ACKed the last received byte
  logic                  oe_q, oe_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_req_q, tx_req_d;
  logic                  busy_q, busy_d;
  logic                  sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (i2c_scl),
    .sda_i      (i2c_sda),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det)
  );

  // Open-drain: only ever pull low; reset releases the line immediately.
  assign i2c_sda  = oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign sh_in    = {shreg_q[I2C_BYTE_W-2:0], sda_s};

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd7;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rw_q       <= 1'b0;
      done_q     <= 1'b0;
      acked_q    <= 1'b0;
      oe_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rw_q       <= rw_d;
      done_q     <= done_d;
      acked_q    <= acked_d;
      oe_q       <= oe_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; START/STOP override everything, SDA drive moves only on scl_fall.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    done_d     = done_q;
    acked_d    = acked_q;
    oe_d       = oe_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd7;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise && !done_q) begin
            shreg_d   = sh_in;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              if (sh_in[7:1] == OWN_ADDR) begin
                rw_d   = sh_in[0];
                done_d = 1'b1;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end else if (scl_fall && done_q) begin
            state_d = ADDR_ACK;
            oe_d    = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd7;
            if (rw_q) begin
              state_d  = TX_DATA;
              shreg_d  = tx_data;
              tx_req_d = 1'b1;
              oe_d     = ~tx_data[7];
            end else begin
              state_d = RX_DATA;
              oe_d    = 1'b0;
            end
          end
        end
        RX_DATA: begin
          if (scl_rise && !done_q) begin
            shreg_d   = sh_in;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              rx_data_d  = sh_in;
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            state_d = RX_ACK;
            oe_d    = rx_ack_en;
            acked_d = rx_ack_en;
            done_d  = 1'b0;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            oe_d = 1'b0;
            if (acked_q) begin
              state_d   = RX_DATA;
              bit_cnt_d = 3'd7;
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        TX_DATA: begin
          if (scl_rise && !done_q) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) done_d = 1'b1;
          end else if (scl_fall) begin
            if (done_q) begin
              state_d = TX_ACK;
              oe_d    = 1'b0;
              done_d  = 1'b0;
            end else begin
              shreg_d = {shreg_q[I2C_BYTE_W-2:0], 1'b0};
              oe_d    = ~shreg_q[6];
            end
          end
        end
        TX_ACK: begin
          // A NACK ends the read at once; surviving to the fall means ACK.
          if (scl_rise && (sda_s == NACK)) begin
            state_d = WAIT_STOP;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            state_d   = TX_DATA;
            shreg_d   = tx_data;
            tx_req_d  = 1'b1;
            oe_d      = ~tx_data[7];
            bit_cnt_d = 3'd7;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target that sits directly downstream of i2c_master on the shared SCL/SDA pair.
- Oversamples SCL/SDA on its own system clock and detects START/STOP.
- Matches a 7-bit address and ACKs it.
- Write transfers: delivers received bytes to local logic.
- Read transfers: shifts out bytes supplied by local logic.
- Serves as the bench-side responder for master verification and as reusable target RTL.

Parameters:
- OWN_ADDR, 7'h50, 7-bit address this target responds to.
- SYNC_STAGES, 2, synchronizer depth for SCL/SDA (minimum 2).

Ports:
- clk  input  1  system clock; must run at least 4x SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- i2c_scl  input  1  I2C clock from master.
- i2c_sda  inout  1  I2C data, open-drain: drives 0 when sda_oe=1, else 'z.
- rx_ack_en  input  1  1 = ACK received data bytes, 0 = NACK them.
- tx_data  input  8  next byte to transmit on a read; sampled at load.
- rx_data  output  8  last received data byte.
- rx_valid  output  1  1-cycle pulse; rx_data updated.
- tx_req  output  1  1-cycle pulse; tx_data just loaded, present next byte before next byte boundary.
- busy  output  1  high from address match until STOP/START/NACK-exit.

Behaviour:
- Reset (reset=0, async):
  - state IDLE; SDA released.
  - rx_data=0, rx_valid=0, tx_req=0, busy=0.
  - Synchronizer flops = 1; bit_cnt=7; shreg=0; rw=0.
- Sampling:
  - SCL and SDA pass through SYNC_STAGES flops plus one delay flop.
  - scl_rise, scl_fall, sda_rise and sda_fall are single-cycle strobes derived from these.
  - Bus latency is SYNC_STAGES+1 clk.
- START = sda_fall while synced SCL=1. STOP = sda_rise while synced SCL=1. These take priority over all state logic in the same cycle.
- START in any state (repeated START included): go to ADDR, bit_cnt=7, release SDA, busy=0.
- STOP in any state: go to IDLE, release SDA, busy=0.
- States: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
- Bit timing:
  - Inputs are sampled on scl_rise.
  - SDA drive changes only on scl_fall, never while SCL is high.
- ADDR:
  - Each scl_rise: shreg = {shreg[6:0], sda}; bit_cnt decrements.
  - At the 8th rise (bit_cnt==0): if shreg[7:1]==OWN_ADDR, latch rw=shreg[0], set match; else go to WAIT_STOP.
  - On the following scl_fall with match: enter ADDR_ACK, drive SDA low, busy=1.
- ADDR_ACK: SDA held low through the ACK clock. On the next scl_fall:
  - rw=0: go to RX_DATA, release SDA, bit_cnt=7.
  - rw=1: go to TX_DATA, load shreg=tx_data, pulse tx_req, drive SDA=~tx_data[7] (low when bit=0), bit_cnt=7.
- RX_DATA:
  - Shift on each scl_rise.
  - After the 8th rise: rx_data=shreg and rx_valid pulses 1 clk. This happens in the same cycle as the 8th rise, with the byte including that rise's bit.
  - Next scl_fall: go to RX_ACK; drive SDA low if rx_ack_en=1 (sampled at that fall), else release.
- RX_ACK: on the next scl_fall, release SDA.
  - If ACKed: go to RX_DATA, bit_cnt=7.
  - If NACKed: go to WAIT_STOP, busy=0.
- TX_DATA:
  - Each scl_fall presents the next bit MSB-first; bit_cnt counts rises.
  - On the scl_fall after the 8th rise: release SDA, go to TX_ACK.
- TX_ACK: on scl_rise, sample the master's ACK.
  - ACK=0: on the next scl_fall, reload shreg=tx_data, pulse tx_req, drive bit 7, go to TX_DATA.
  - ACK=1: go to WAIT_STOP, SDA released, busy=0.
- WAIT_STOP: ignores SCL; exits only on START or STOP.
- Boundaries:
  - SDA is never driven in IDLE or WAIT_STOP.
  - START and STOP in the same clk cannot occur; if both strobes assert, START wins.
  - Reset mid-byte releases SDA asynchronously.
  - rx_valid and tx_req never assert together.

Decomposition:
- i2c_pkg holds:
  - typedef enum logic [2:0] slave_state_t (8 states above);
  - I2C_ADDR_W=7, I2C_BYTE_W=8;
  - ACK=1'b0 and NACK=1'b1 constants.
- One sub-module: i2c_bus_sync. It synchronizes SCL/SDA and emits scl_rise, scl_fall, start_det and stop_det. The FSM/shift logic stays in i2c_slave.

Test Plan:
- Write address 7'h50 with data 8'hA5, 8'h3C, then STOP, rx_ack_en=1:
  - ACK on address and both bytes;
  - rx_valid pulses twice with rx_data 8'hA5 then 8'h3C;
  - busy falls on STOP.
- Address 7'h51 with data 8'hFF:
  - SDA never driven low by the slave;
  - no rx_valid;
  - state WAIT_STOP until STOP.
- Read from 7'h50, tx_data=8'h96 then 8'h0F, master ACKs the first byte and NACKs the second:
  - SDA carries 1001_0110 then 0000_1111;
  - tx_req pulses twice;
  - SDA released after the NACK.
- Write with rx_ack_en=0 on the first data byte 8'h11:
  - rx_valid pulses with 8'h11;
  - ACK slot reads 1;
  - following byte is ignored.
- Repeated START mid-byte after 3 data bits, then read of 7'h50:
  - bit_cnt restarts;
  - address ACKed;
  - no partial rx_valid.
- Assert reset low in TX_DATA while driving a 0 bit: SDA releases immediately; all outputs return to reset values.
